ex_stage_ctrl: RTL and testbench

Hazard and sequencing controller for the execute stage. It computes the per-operand forwarding selects that steer the ALU input muxes, and it detects load-use hazards and inserts a bubble into EX. It also schedules the iterative multiply/divide unit that shares the EX slot: while that unit is busy, the pipeline is frozen through the EX stage `enable` and a one-cycle `md_step` strobe is issued per iteration. It sits beside the EX stage and drives that stage's `inForwardA`, `inForwardB`, `enable` and `inEX_Flush` inputs.

---
 rtl/ex_stage_ctrl.sv | 140 ++++++++++++++
 tb/tb_ex_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl
//   Execute-stage hazard and sequencing controller.
//   - Forwarding selects for ALU operands A (exRs) and B (exRt):
//     01 = EX/MEM result, 10 = MEM/WB result, 00 = register file.
//   - Load-use hazard detection: stalls IF/ID and bubbles EX.
//   - Scheduler for the iterative mul/div unit sharing the EX slot.
//     EX is frozen while the unit runs, and one md_step strobe is
//     issued per iteration.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   idRs, idRt                  source registers of the IF/ID instruction
//   exRs, exRt                  source registers of the ID/EX instruction
//   exMemRead, exMdStart        ID/EX instruction is a load / mul-div
//   memRegWrite, memRd          EX/MEM write-back enable and destination
//   wbRegWrite, wbRd            MEM/WB write-back enable and destination
//   branchFlush                 taken branch/jump; kills younger work
//   outForwardA, outForwardB    ALU operand mux selects
//   outStallIF                  hold PC and IF/ID
//   outEnable                   EX/MEM latch enable
//   outEX_Flush                 bubble into EX/MEM
//   outMdStep, outMdDone        mul/div iteration strobe / result valid
//   outMdBusy                   mul/div iterating
module ex_stage_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic [4:0] exRs,
    input  logic [4:0] exRt,
    input  logic       exMemRead,
    input  logic       exMdStart,
    input  logic       memRegWrite,
    input  logic [4:0] memRd,
    input  logic       wbRegWrite,
    input  logic [4:0] wbRd,
    input  logic       branchFlush,
    output logic [1:0] outForwardA,
    output logic [1:0] outForwardB,
    output logic       outStallIF,
    output logic       outEnable,
    output logic       outEX_Flush,
    output logic       outMdStep,
    output logic       outMdDone,
    output logic       outMdBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu;
    logic             start_req;

    // EX/MEM has priority over MEM/WB; register 0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b01;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign outForwardA = fwd_sel(exRs, memRegWrite, memRd, wbRegWrite, wbRd);
    assign outForwardB = fwd_sel(exRt, memRegWrite, memRd, wbRegWrite, wbRd);

    assign lu = exMemRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));

    // A load-use hazard outranks a mul/div start, so the start is
    // neither accepted nor allowed to freeze the latch in that case.
    assign start_req = exMdStart && !lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        outMdStep = 1'b0;
        outMdDone = 1'b0;
        case (state)
            IDLE: begin
                if (start_req && !branchFlush) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                outMdStep = 1'b1;
                if (branchFlush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                // Any start seen here belongs to the completing instruction.
                outMdDone = !branchFlush;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign outMdBusy   = (state == BUSY);
    assign outEnable   = !outMdBusy && !((state == IDLE) && start_req);
    assign outStallIF  = lu || !outEnable;
    assign outEX_Flush = branchFlush || lu;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb_ex_stage_ctrl
//   Bench for ex_stage_ctrl. Two instances (MD_LAT = 4 and 32) share all
//   inputs. A timeline model, tracking each operation by its start cycle,
//   predicts the outputs and is compared on every falling edge; directed
//   stimulus adds hand-computed literal checks.
module tb_ex_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] idRs, idRt, exRs, exRt, memRd, wbRd;
    logic       exMemRead, exMdStart, memRegWrite, wbRegWrite, branchFlush;

    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic       stall [2];
    logic       en [2];
    logic       fl [2];
    logic       step [2];
    logic       done [2];
    logic       busy [2];

    int n_chk  = 0;
    int n_fail = 0;

    int unsigned lat [2] = '{4, 32};
    bit          m_act [2];
    int          m_start [2];
    int          cycle = 0;

    always #5 clk = ~clk;

    ex_stage_ctrl #(.MD_LAT(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt), .exRs(exRs), .exRt(exRt),
        .exMemRead(exMemRead), .exMdStart(exMdStart), .memRegWrite(memRegWrite),
        .memRd(memRd), .wbRegWrite(wbRegWrite), .wbRd(wbRd), .branchFlush(branchFlush),
        .outForwardA(fa[0]), .outForwardB(fb[0]), .outStallIF(stall[0]),
        .outEnable(en[0]), .outEX_Flush(fl[0]), .outMdStep(step[0]),
        .outMdDone(done[0]), .outMdBusy(busy[0])
    );

    ex_stage_ctrl #(.MD_LAT(32), .CNT_W(6)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt), .exRs(exRs), .exRt(exRt),
        .exMemRead(exMemRead), .exMdStart(exMdStart), .memRegWrite(memRegWrite),
        .memRd(memRd), .wbRegWrite(wbRegWrite), .wbRd(wbRd), .branchFlush(branchFlush),
        .outForwardA(fa[1]), .outForwardB(fb[1]), .outStallIF(stall[1]),
        .outEnable(en[1]), .outEX_Flush(fl[1]), .outMdStep(step[1]),
        .outMdDone(done[1]), .outMdBusy(busy[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_fwd(input logic [4:0] r);
        if (memRegWrite && memRd != 0 && memRd == r) return 1;
        if (wbRegWrite && wbRd != 0 && wbRd == r) return 2;
        return 0;
    endfunction

    // Model: an operation started in cycle S is busy for S+1..S+L and
    // completes in S+L+1; a flush after S cancels it.
    always @(negedge clk) begin : model_cmp
        bit lu_e, busy_e, donest_e, idle_e, en_e;
        int k;
        if (!rst_n) begin
            m_act[0] = 1'b0;
            m_act[1] = 1'b0;
        end
        lu_e = exMemRead && exRt != 0 && (exRt == idRs || exRt == idRt);
        for (int i = 0; i < 2; i++) begin
            k        = cycle - m_start[i];
            busy_e   = m_act[i] && k >= 1 && k <= int'(lat[i]);
            donest_e = m_act[i] && k == int'(lat[i]) + 1;
            idle_e   = !busy_e && !donest_e;
            en_e     = !busy_e && !(idle_e && exMdStart && !lu_e);
            chk($sformatf("L%0d_fwdA", lat[i]), fa[i], exp_fwd(exRs));
            chk($sformatf("L%0d_fwdB", lat[i]), fb[i], exp_fwd(exRt));
            chk($sformatf("L%0d_busy", lat[i]), busy[i], busy_e);
            chk($sformatf("L%0d_step", lat[i]), step[i], busy_e);
            chk($sformatf("L%0d_done", lat[i]), done[i], donest_e && !branchFlush);
            chk($sformatf("L%0d_enable", lat[i]), en[i], en_e);
            chk($sformatf("L%0d_stallIF", lat[i]), stall[i], lu_e || !en_e);
            chk($sformatf("L%0d_exflush", lat[i]), fl[i], branchFlush || lu_e);
            if (rst_n) begin
                if (donest_e || (busy_e && branchFlush)) m_act[i] = 1'b0;
                if (idle_e && exMdStart && !branchFlush && !lu_e) begin
                    m_act[i]   = 1'b1;
                    m_start[i] = cycle;
                end
            end
        end
        cycle++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int steps;
        int frozen;
        rst_n = 1'b0;
        {idRs, idRt, exRs, exRt, memRd, wbRd} = '0;
        {exMemRead, exMdStart, memRegWrite, wbRegWrite, branchFlush} = '0;
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        m_start[0] = 0;
        m_start[1] = 0;

        cyc(); cyc();
        chk("rst_enable", en[0], 1);
        chk("rst_stallIF", stall[0], 0);
        chk("rst_exflush", fl[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_fwdA", fa[0], 0);
        rst_n = 1'b1;

        // Forwarding
        cyc();
        memRegWrite = 1; memRd = 5; wbRegWrite = 1; wbRd = 5; exRs = 5; exRt = 5;
        #1;
        chk("t1_memfwdA", fa[0], 1);
        chk("t1_memfwdB", fb[0], 1);
        cyc();
        memRd = 7;
        #1;
        chk("t1_wbfwdA", fa[0], 2);
        chk("t1_wbfwdB", fb[0], 2);
        cyc();
        memRd = 0; wbRd = 0; exRs = 0;
        #1;
        chk("t1_r0fwdA", fa[0], 0);
        chk("t1_r0fwdB", fb[0], 0);
        cyc();
        memRd = 9; wbRd = 4; exRs = 4; exRt = 9;
        #1;
        chk("t1_mixA", fa[0], 2);
        chk("t1_mixB", fb[0], 1);
        cyc();
        {memRegWrite, wbRegWrite, memRd, wbRd, exRs, exRt} = '0;

        // Load-use
        exMemRead = 1; exRt = 3; idRt = 3;
        #1;
        chk("t2_stall", stall[0], 1);
        chk("t2_flush", fl[0], 1);
        chk("t2_enable", en[0], 1);
        cyc();
        exRt = 0; idRt = 0;
        #1;
        chk("t2_r0stall", stall[0], 0);
        chk("t2_r0flush", fl[0], 0);
        cyc();
        exMemRead = 0;

        // Mul/div, MD_LAT = 4
        exMdStart = 1;
        #1;
        chk("t3_en_T", en[0], 0);
        steps = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) exMdStart = 0;
            #1;
            steps += int'(step[0]);
            chk($sformatf("t3_busy_k%0d", k), busy[0], (k <= 4) ? 1 : 0);
            chk($sformatf("t3_en_k%0d", k), en[0], (k >= 5) ? 1 : 0);
            chk($sformatf("t3_done_k%0d", k), done[0], (k == 5) ? 1 : 0);
        end
        chk("t3_steps", steps, 4);
        repeat (30) cyc();

        // Flush mid-BUSY, MD_LAT = 32
        exMdStart = 1;
        cyc();
        exMdStart = 0;
        repeat (9) cyc();
        branchFlush = 1;
        #1;
        chk("t4_busy_pre", busy[1], 1);
        chk("t4_flush", fl[1], 1);
        cyc();
        branchFlush = 0;
        #1;
        chk("t4_busy_post", busy[1], 0);
        chk("t4_en_post", en[1], 1);
        for (int k = 0; k < 30; k++) begin
            cyc();
            chk("t4_nodone", done[1], 0);
        end

        // Asynchronous reset mid-BUSY
        exMdStart = 1;
        cyc();
        exMdStart = 0;
        repeat (9) cyc();
        #2;
        chk("t5_busy_before", busy[1], 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy[1], 0);
        chk("t5_step", step[1], 0);
        chk("t5_enable", en[1], 1);
        chk("t5_stallIF", stall[1], 0);
        chk("t5_done", done[1], 0);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            chk("t5_nodone", done[1], 0);
            chk("t5_idle", busy[1], 0);
        end

        // Back-to-back, start held through DONE (MD_LAT = 4)
        exMdStart = 1;
        #1;
        frozen = en[0] ? 0 : 1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 7) exMdStart = 0;
            #1;
            frozen += en[0] ? 0 : 1;
            if (k == 5)  chk("t6_done1", done[0], 1);
            if (k == 6)  chk("t6_start2_busy", busy[0], 0);
            if (k == 6)  chk("t6_start2_en", en[0], 0);
            if (k == 7)  chk("t6_busy2", busy[0], 1);
            if (k == 11) chk("t6_done2", done[0], 1);
        end
        chk("t6_frozen", frozen, 10);
        repeat (40) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
